// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit for the in-order RISC core.
// Decodes the ID instruction, carries its control bits through EX, MEM and
// WB, stalls on load-use hazards, kills the ID slot on a taken branch and
// keeps a saturating count of dropped illegal instructions.
//
// Handshake: the ID slot offers an instruction with id_valid; it is consumed
// on a rising edge only when id_ready is high (id_valid & ~stall & ~flush).
// While id_ready is low the upstream must hold the same instruction. EX,
// MEM and WB never back-pressure; they advance every cycle.
module pipe_ctrl_unit #(
  parameter int OP_W  = 6,
  parameter int FN_W  = 6,
  parameter int RA_W  = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [OP_W-1:0]  id_opcode,
  input  logic [FN_W-1:0]  id_funct,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             flush,
  output logic             id_ready,
  output logic             stall,
  output logic             ex_valid,
  output logic [1:0]       ex_alu_op,
  output logic             ex_is_branch,
  output logic             mem_dm_we,
  output logic             mem_dm_re,
  output logic             wb_rf_we,
  output logic [RA_W-1:0]  wb_waddr,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [OP_W-1:0] OPC_NOP   = OP_W'(0);
  localparam logic [OP_W-1:0] OPC_R     = OP_W'(1);
  localparam logic [OP_W-1:0] OPC_LOAD  = OP_W'(2);
  localparam logic [OP_W-1:0] OPC_STORE = OP_W'(3);
  localparam logic [OP_W-1:0] OPC_ADDI  = OP_W'(4);
  localparam logic [OP_W-1:0] OPC_BEQ   = OP_W'(5);
  localparam logic [FN_W-1:0] FN_ADD    = FN_W'(1);
  localparam logic [FN_W-1:0] FN_SUB    = FN_W'(2);

  // Decoded ID control bits
  logic            d_legal, d_nop, d_rf_we, d_dm_we, d_dm_re, d_br, d_uses_rt;
  logic [1:0]      d_alu;
  logic [RA_W-1:0] d_waddr;

  // EX / MEM / WB stage registers
  logic            ex_v, ex_rf_we, ex_dm_we, ex_dm_re, ex_br;
  logic [1:0]      ex_alu;
  logic [RA_W-1:0] ex_waddr;
  logic            mem_v, mem_rf_we, mem_we, mem_re;
  logic [RA_W-1:0] mem_waddr;
  logic            wb_v, wb_we;
  logic [RA_W-1:0] wb_wa;

  logic            ex_load;
  logic            ill_accept;

  // Decode table; a write to r0 is turned into no write at all
  always_comb begin
    d_legal   = 1'b1;
    d_nop     = 1'b0;
    d_rf_we   = 1'b0;
    d_dm_we   = 1'b0;
    d_dm_re   = 1'b0;
    d_br      = 1'b0;
    d_uses_rt = 1'b0;
    d_alu     = 2'd0;
    d_waddr   = '0;
    case (id_opcode)
      OPC_NOP: d_nop = 1'b1;
      OPC_R: begin
        if (id_funct == FN_ADD || id_funct == FN_SUB) begin
          d_rf_we   = 1'b1;
          d_alu     = (id_funct == FN_ADD) ? 2'd1 : 2'd2;
          d_waddr   = id_rd;
          d_uses_rt = 1'b1;
        end else begin
          d_legal = 1'b0;
        end
      end
      OPC_LOAD: begin
        d_rf_we = 1'b1;
        d_dm_re = 1'b1;
        d_waddr = id_rt;
      end
      OPC_STORE: begin
        d_dm_we   = 1'b1;
        d_uses_rt = 1'b1;
      end
      OPC_ADDI: begin
        d_rf_we = 1'b1;
        d_alu   = 2'd1;
        d_waddr = id_rt;
      end
      OPC_BEQ: begin
        d_br      = 1'b1;
        d_alu     = 2'd3;
        d_uses_rt = 1'b1;
      end
      default: d_legal = 1'b0;
    endcase
    if (d_waddr == '0) d_rf_we = 1'b0;
  end

  // A load in EX whose destination ID reads must wait one cycle; flush wins
  assign stall = id_valid && !flush && ex_v && ex_dm_re && (ex_waddr != '0) &&
                 ((ex_waddr == id_rs) || (d_uses_rt && ex_waddr == id_rt));

  assign id_ready   = id_valid & ~stall & ~flush;
  assign ex_load    = id_ready & d_legal & ~d_nop;
  assign ill_accept = id_ready & ~d_legal;

  // EX stage: real instruction when accepted and meaningful, bubble otherwise
  always_ff @(posedge clk) begin
    if (reset || !ex_load) begin
      ex_v     <= 1'b0;
      ex_rf_we <= 1'b0;
      ex_dm_we <= 1'b0;
      ex_dm_re <= 1'b0;
      ex_br    <= 1'b0;
      ex_alu   <= 2'd0;
      ex_waddr <= '0;
    end else begin
      ex_v     <= 1'b1;
      ex_rf_we <= d_rf_we;
      ex_dm_we <= d_dm_we;
      ex_dm_re <= d_dm_re;
      ex_br    <= d_br;
      ex_alu   <= d_alu;
      ex_waddr <= d_waddr;
    end
  end

  // MEM and WB shift forward unconditionally
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_v     <= 1'b0;
      mem_rf_we <= 1'b0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_waddr <= '0;
      wb_v      <= 1'b0;
      wb_we     <= 1'b0;
      wb_wa     <= '0;
    end else begin
      mem_v     <= ex_v;
      mem_rf_we <= ex_rf_we;
      mem_we    <= ex_dm_we;
      mem_re    <= ex_dm_re;
      mem_waddr <= ex_waddr;
      wb_v      <= mem_v;
      wb_we     <= mem_rf_we;
      wb_wa     <= mem_waddr;
    end
  end

  // Illegal pulse and saturating counter, updated together on acceptance
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal     <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      illegal <= ill_accept;
      if (ill_accept && illegal_cnt != {CNT_W{1'b1}})
        illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

  assign ex_valid     = ex_v;
  assign ex_alu_op    = ex_alu;
  assign ex_is_branch = ex_v & ex_br;
  assign mem_dm_we    = mem_v & mem_we;
  assign mem_dm_re    = mem_v & mem_re;
  assign wb_rf_we     = wb_v & wb_we;
  assign wb_waddr     = wb_wa;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: directed instruction sequences, a cycle model of
// the control flow kept as a record per stage, and literal spot checks.
module tb_pipe_ctrl_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [5:0] id_opcode, id_funct;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       flush;

  logic       id_ready, stall, ex_valid, ex_is_branch, mem_dm_we, mem_dm_re;
  logic       wb_rf_we, illegal;
  logic [1:0] ex_alu_op;
  logic [4:0] wb_waddr;
  logic [7:0] illegal_cnt;

  logic       id_ready2, stall2, ex_valid2, ex_is_branch2, mem_dm_we2, mem_dm_re2;
  logic       wb_rf_we2, illegal2;
  logic [1:0] ex_alu_op2;
  logic [4:0] wb_waddr2;
  logic [1:0] illegal_cnt2;

  int checks = 0;
  int errors = 0;

  pipe_ctrl_unit dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .flush(flush), .id_ready(id_ready), .stall(stall), .ex_valid(ex_valid),
    .ex_alu_op(ex_alu_op), .ex_is_branch(ex_is_branch), .mem_dm_we(mem_dm_we),
    .mem_dm_re(mem_dm_re), .wb_rf_we(wb_rf_we), .wb_waddr(wb_waddr),
    .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  pipe_ctrl_unit #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .flush(flush), .id_ready(id_ready2), .stall(stall2), .ex_valid(ex_valid2),
    .ex_alu_op(ex_alu_op2), .ex_is_branch(ex_is_branch2), .mem_dm_we(mem_dm_we2),
    .mem_dm_re(mem_dm_re2), .wb_rf_we(wb_rf_we2), .wb_waddr(wb_waddr2),
    .illegal(illegal2), .illegal_cnt(illegal_cnt2)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model ----------------
  typedef struct packed {
    logic       v;
    logic       legal;
    logic       nop;
    logic       uses_rt;
    logic       rf_we;
    logic       dm_we;
    logic       dm_re;
    logic       br;
    logic [1:0] alu;
    logic [4:0] waddr;
  } instr_t;

  instr_t m_ex, m_mem, m_wb;
  logic   m_ill;
  int     m_cnt;
  logic   model_live = 1'b0;

  function automatic instr_t decode(logic [5:0] op, logic [5:0] fn,
                                    logic [4:0] rt, logic [4:0] rd);
    instr_t d;
    logic   writes;
    d = '0;
    d.v = 1'b1;
    d.legal = 1'b1;
    writes = 1'b0;
    if (op == 0) d.nop = 1'b1;
    else if (op == 1 && (fn == 1 || fn == 2)) begin
      writes = 1'b1; d.alu = (fn == 1) ? 2'd1 : 2'd2; d.waddr = rd; d.uses_rt = 1'b1;
    end else if (op == 2) begin
      writes = 1'b1; d.dm_re = 1'b1; d.waddr = rt;
    end else if (op == 3) begin
      d.dm_we = 1'b1; d.uses_rt = 1'b1;
    end else if (op == 4) begin
      writes = 1'b1; d.alu = 2'd1; d.waddr = rt;
    end else if (op == 5) begin
      d.br = 1'b1; d.alu = 2'd3; d.uses_rt = 1'b1;
    end else d.legal = 1'b0;
    d.rf_we = writes && (d.waddr != 0);
    return d;
  endfunction

  function automatic logic hazard(instr_t ex, instr_t d);
    if (!id_valid || flush || !ex.v || !ex.dm_re || ex.waddr == 0) return 1'b0;
    return (ex.waddr == id_rs) || (d.uses_rt && ex.waddr == id_rt);
  endfunction

  // advance the model on each rising edge from the inputs it sees
  always @(posedge clk) begin
    instr_t d;
    logic   acc;
    if (reset) begin
      m_ex = '0; m_mem = '0; m_wb = '0; m_ill = 1'b0; m_cnt = 0;
      model_live = 1'b1;
    end else begin
      d = decode(id_opcode, id_funct, id_rt, id_rd);
      acc = id_valid && !flush && !hazard(m_ex, d);
      m_wb = m_mem;
      m_mem = m_ex;
      m_ex = (acc && d.legal && !d.nop) ? d : '0;
      m_ill = acc && !d.legal;
      if (m_ill) m_cnt++;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // every falling edge: all outputs of both instances against the model
  always @(negedge clk) begin
    instr_t d;
    logic   e_stall;
    if (model_live) begin
      d = decode(id_opcode, id_funct, id_rt, id_rd);
      e_stall = hazard(m_ex, d);
      chk("stall", {31'd0, stall}, {31'd0, e_stall});
      chk("id_ready", {31'd0, id_ready}, {31'd0, id_valid & ~e_stall & ~flush});
      chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_ex.v});
      chk("ex_alu_op", {30'd0, ex_alu_op}, {30'd0, m_ex.alu});
      chk("ex_is_branch", {31'd0, ex_is_branch}, {31'd0, m_ex.v & m_ex.br});
      chk("mem_dm_we", {31'd0, mem_dm_we}, {31'd0, m_mem.v & m_mem.dm_we});
      chk("mem_dm_re", {31'd0, mem_dm_re}, {31'd0, m_mem.v & m_mem.dm_re});
      chk("wb_rf_we", {31'd0, wb_rf_we}, {31'd0, m_wb.v & m_wb.rf_we});
      chk("wb_waddr", {27'd0, wb_waddr}, {27'd0, m_wb.waddr});
      chk("illegal", {31'd0, illegal}, {31'd0, m_ill});
      chk("illegal_cnt", {24'd0, illegal_cnt}, (m_cnt > 255) ? 32'd255 : 32'(m_cnt));
      chk("cnt2_outs", {23'd0, id_ready2, stall2, ex_valid2, ex_alu_op2, ex_is_branch2,
                        mem_dm_we2, mem_dm_re2, wb_rf_we2},
                       {23'd0, id_ready, stall, ex_valid, ex_alu_op, ex_is_branch,
                        mem_dm_we, mem_dm_re, wb_rf_we});
      chk("cnt2_wa_ill", {26'd0, wb_waddr2, illegal2}, {26'd0, wb_waddr, illegal});
      chk("illegal_cnt2", {30'd0, illegal_cnt2}, (m_cnt > 3) ? 32'd3 : 32'(m_cnt));
    end
  end

  // ---------------- driver ----------------
  task automatic set_in(logic v, logic [5:0] op, logic [5:0] fn, logic [4:0] rs,
                        logic [4:0] rt, logic [4:0] rd, logic fl);
    id_valid = v; id_opcode = op; id_funct = fn;
    id_rs = rs; id_rt = rt; id_rd = rd; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(logic [5:0] op, logic [5:0] fn, logic [4:0] rs,
                      logic [4:0] rt, logic [4:0] rd);
    set_in(1'b1, op, fn, rs, rt, rd, 1'b0);
    tick();
  endtask

  task automatic idle(int n);
    set_in(1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b1;
    set_in(1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick(); tick();
    reset = 1'b0;
    chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_cnt", {24'd0, illegal_cnt}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);

    // ADD r1 = r2 + r3
    step(6'd1, 6'd1, 5'd2, 5'd3, 5'd1);
    chk("add_ex_alu", {30'd0, ex_alu_op}, 32'd1);
    idle(2);
    chk("add_wb_we", {31'd0, wb_rf_we}, 32'd1);
    chk("add_wb_wa", {27'd0, wb_waddr}, 32'd1);

    // STORE rs=4, rt=5
    step(6'd3, 6'd0, 5'd4, 5'd5, 5'd0);
    idle(1);
    chk("st_mem_we", {31'd0, mem_dm_we}, 32'd1);
    idle(1);
    chk("st_mem_we_off", {31'd0, mem_dm_we}, 32'd0);
    chk("st_wb_we", {31'd0, wb_rf_we}, 32'd0);

    // LOAD r6, then ADD r7 = r6 + r2: one stall cycle
    step(6'd2, 6'd0, 5'd1, 5'd6, 5'd0);
    set_in(1'b1, 6'd1, 6'd1, 5'd6, 5'd2, 5'd7, 1'b0);
    #1;
    chk("lu_stall", {31'd0, stall}, 32'd1);
    chk("lu_ready", {31'd0, id_ready}, 32'd0);
    tick();
    chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
    chk("lu_stall_off", {31'd0, stall}, 32'd0);
    tick();
    idle(2);
    chk("lu_wb_we", {31'd0, wb_rf_we}, 32'd1);
    chk("lu_wb_wa", {27'd0, wb_waddr}, 32'd7);

    // LOAD r0, then ADD reading r0: no stall
    step(6'd2, 6'd0, 5'd1, 5'd0, 5'd0);
    set_in(1'b1, 6'd1, 6'd1, 5'd0, 5'd0, 5'd9, 1'b0);
    #1;
    chk("lu_r0_stall", {31'd0, stall}, 32'd0);
    tick();
    idle(3);

    // ADDI rt=0 never writes
    step(6'd4, 6'd0, 5'd3, 5'd0, 5'd0);
    idle(2);
    chk("addi_r0_we", {31'd0, wb_rf_we}, 32'd0);

    // BEQ then flushed ADD r8
    step(6'd5, 6'd0, 5'd1, 5'd2, 5'd0);
    chk("beq_branch", {31'd0, ex_is_branch}, 32'd1);
    chk("beq_alu", {30'd0, ex_alu_op}, 32'd3);
    set_in(1'b1, 6'd1, 6'd1, 5'd1, 5'd2, 5'd8, 1'b1);
    #1;
    chk("flush_ready", {31'd0, id_ready}, 32'd0);
    tick();
    idle(2);
    chk("flush_wb_we", {31'd0, wb_rf_we}, 32'd0);

    // flush during a load-use hazard suppresses the stall
    step(6'd2, 6'd0, 5'd1, 5'd6, 5'd0);
    set_in(1'b1, 6'd1, 6'd1, 5'd6, 5'd2, 5'd7, 1'b1);
    #1;
    chk("flush_stall", {31'd0, stall}, 32'd0);
    tick();
    idle(3);

    // illegal: opcode 9, then opcode 1 funct 7
    step(6'd9, 6'd0, 5'd0, 5'd0, 5'd0);
    chk("ill1_pulse", {31'd0, illegal}, 32'd1);
    chk("ill1_cnt", {24'd0, illegal_cnt}, 32'd1);
    step(6'd1, 6'd7, 5'd0, 5'd0, 5'd0);
    chk("ill2_pulse", {31'd0, illegal}, 32'd1);
    chk("ill2_cnt", {24'd0, illegal_cnt}, 32'd2);
    chk("ill2_ex", {31'd0, ex_valid}, 32'd0);
    idle(1);
    chk("ill_pulse_off", {31'd0, illegal}, 32'd0);
    for (int i = 0; i < 5; i++) step(6'd63, 6'd0, 5'd0, 5'd0, 5'd0);
    idle(1);
    chk("ill_cnt7", {24'd0, illegal_cnt}, 32'd7);
    chk("ill_cnt2_sat", {30'd0, illegal_cnt2}, 32'd3);

    // reset while ADD is in MEM and LOAD is in EX
    step(6'd1, 6'd1, 5'd2, 5'd3, 5'd1);
    step(6'd2, 6'd0, 5'd1, 5'd6, 5'd0);
    set_in(1'b1, 6'd1, 6'd1, 5'd6, 5'd2, 5'd7, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle(0);
    chk("mid_rst_ex", {31'd0, ex_valid}, 32'd0);
    chk("mid_rst_mem", {31'd0, mem_dm_re}, 32'd0);
    chk("mid_rst_wb", {31'd0, wb_rf_we}, 32'd0);
    chk("mid_rst_cnt", {24'd0, illegal_cnt}, 32'd0);
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
